// File: rtl/top_result_accumulator_if.sv
// Handshake bundle for top_result_accumulator: top start, result-word stream and aggregated record.
// The outOverflow signal exists only when TOP_ACC_OVERFLOW_DETECT_EN is defined.
interface top_result_accumulator_if #(
    parameter int SUM_WIDTH    = 64,
    parameter int PCOEFF_WIDTH = 32,
    parameter int COUNT_WIDTH  = 32
);
    logic                    startTop;
    logic [COUNT_WIDTH-1:0]  expectedCount;
    logic                    topReady;
    logic                    inValid;
    logic                    inReady;
    logic [63:0]             inData;
    logic                    outValid;
    logic                    outReady;
    logic [SUM_WIDTH-1:0]    outSum;
    logic [PCOEFF_WIDTH-1:0] outPcoeff;
    logic [COUNT_WIDTH-1:0]  outCount;
`ifdef TOP_ACC_OVERFLOW_DETECT_EN
    logic                    outOverflow;
`endif

    modport slave (
        input  startTop, expectedCount, inValid, inData, outReady,
        output topReady, inReady, outValid, outSum, outPcoeff, outCount
`ifdef TOP_ACC_OVERFLOW_DETECT_EN
        , output outOverflow
`endif
    );

    modport master (
        output startTop, expectedCount, inValid, inData, outReady,
        input  topReady, inReady, outValid, outSum, outPcoeff, outCount
`ifdef TOP_ACC_OVERFLOW_DETECT_EN
        , input outOverflow
`endif
    );
endinterface

// File: rtl/top_result_accumulator.sv
// Sums one top's result words ({pcoeffCount[15:0], summedData[47:0]}) into a single record.
// Define TOP_ACC_OVERFLOW_DETECT_EN to add the sticky outOverflow flag.
module top_result_accumulator #(
    parameter int SUM_WIDTH    = 64,
    parameter int PCOEFF_WIDTH = 32,
    parameter int COUNT_WIDTH  = 32
) (
    input  logic clock,
    input  logic resetn,
    top_result_accumulator_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_EMIT  = 2'd2;

    logic [1:0]              r_state;
    logic [SUM_WIDTH-1:0]    r_sum;
    logic [PCOEFF_WIDTH-1:0] r_pcoeff;
    logic [COUNT_WIDTH-1:0]  r_expected;
    logic [COUNT_WIDTH-1:0]  r_received;

    logic                    w_wordAccept;
    logic                    w_lastWord;
    logic [SUM_WIDTH-1:0]    w_sumAdd;
    logic [PCOEFF_WIDTH-1:0] w_pcoeffAdd;
    logic [SUM_WIDTH-1:0]    w_sumNext;
    logic [PCOEFF_WIDTH-1:0] w_pcoeffNext;

    assign w_wordAccept = (r_state == S_ACCUM) && bus.inValid;
    assign w_lastWord   = w_wordAccept && ((r_received + COUNT_WIDTH'(1)) == r_expected);
    assign w_sumAdd     = SUM_WIDTH'(bus.inData[47:0]);
    assign w_pcoeffAdd  = PCOEFF_WIDTH'(bus.inData[63:48]);

`ifdef TOP_ACC_OVERFLOW_DETECT_EN
    logic w_sumCarry;
    logic w_pcoeffCarry;
    logic r_overflow;

    assign {w_sumCarry, w_sumNext}       = {1'b0, r_sum} + {1'b0, w_sumAdd};
    assign {w_pcoeffCarry, w_pcoeffNext} = {1'b0, r_pcoeff} + {1'b0, w_pcoeffAdd};

    // Sticky across the whole top; only a newly accepted top clears it.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_overflow <= 1'b0;
        end else if ((r_state == S_IDLE) && bus.startTop) begin
            r_overflow <= 1'b0;
        end else if (w_wordAccept && (w_sumCarry || w_pcoeffCarry)) begin
            r_overflow <= 1'b1;
        end
    end

    assign bus.outOverflow = r_overflow;
`else
    assign w_sumNext    = r_sum + w_sumAdd;
    assign w_pcoeffNext = r_pcoeff + w_pcoeffAdd;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_sum      <= '0;
            r_pcoeff   <= '0;
            r_expected <= '0;
            r_received <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.startTop) begin
                        r_expected <= bus.expectedCount;
                        r_sum      <= '0;
                        r_pcoeff   <= '0;
                        r_received <= '0;
                        r_state    <= (bus.expectedCount == '0) ? S_EMIT : S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (w_wordAccept) begin
                        r_sum      <= w_sumNext;
                        r_pcoeff   <= w_pcoeffNext;
                        r_received <= r_received + COUNT_WIDTH'(1);
                        if (w_lastWord) begin
                            r_state <= S_EMIT;
                        end
                    end
                end
                S_EMIT: begin
                    if (bus.outReady) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Handshake outputs decode from state alone; the record is the live accumulator.
    assign bus.topReady  = (r_state == S_IDLE);
    assign bus.inReady   = (r_state == S_ACCUM);
    assign bus.outValid  = (r_state == S_EMIT);
    assign bus.outSum    = r_sum;
    assign bus.outPcoeff = r_pcoeff;
    assign bus.outCount  = r_received;
endmodule

// File: tb/tb_top_result_accumulator.sv
// Randomized self-checking bench for top_result_accumulator against a plain-arithmetic model.
// Honours TOP_ACC_OVERFLOW_DETECT_EN when the design is built with it.
module tb_top_result_accumulator;
    localparam int SUM_W    = 48;
    localparam int PCOEFF_W = 32;
    localparam int COUNT_W  = 32;

    logic clock;
    logic resetn;
    int   checkCount;
    int   errorCount;
    logic [63:0] wordQ[$];

    top_result_accumulator_if #(.SUM_WIDTH(SUM_W), .PCOEFF_WIDTH(PCOEFF_W), .COUNT_WIDTH(COUNT_W)) bus ();

    top_result_accumulator #(.SUM_WIDTH(SUM_W), .PCOEFF_WIDTH(PCOEFF_W), .COUNT_WIDTH(COUNT_W)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    // Runs one top over wordQ; record expectations come from the true (unbounded) totals.
    task automatic applyStimulus(input int gapPct, input int holdCycles);
        int          n;
        int          budget;
        logic        accepted;
        logic [63:0] trueSum;
        logic [63:0] truePc;
        logic [63:0] expSum;
        logic [63:0] expPc;
        logic        expOvf;
        n       = wordQ.size();
        trueSum = '0;
        truePc  = '0;
        foreach (wordQ[i]) begin
            trueSum = trueSum + {16'h0, wordQ[i][47:0]};
            truePc  = truePc + {48'h0, wordQ[i][63:48]};
        end
        expSum = trueSum % (64'd1 << SUM_W);
        expPc  = truePc % (64'd1 << PCOEFF_W);
        expOvf = (trueSum >= (64'd1 << SUM_W)) || (truePc >= (64'd1 << PCOEFF_W));

        budget = 0;
        while (!bus.topReady && budget < 100) begin
            nextCycle();
            budget++;
        end
        checkOutput("topReadyBeforeStart", {63'h0, bus.topReady}, 64'd1);
        bus.startTop      = 1'b1;
        bus.expectedCount = COUNT_W'(n);
        nextCycle();
        bus.startTop = 1'b0;
        if (n == 0) begin
            checkOutput("zeroInReady", {63'h0, bus.inReady}, 64'd0);
        end else begin
            checkOutput("accumInReady", {63'h0, bus.inReady}, 64'd1);
        end

        for (int i = 0; i < n; i++) begin
            while ($urandom_range(99) < gapPct) begin
                bus.inValid = 1'b0;
                bus.inData  = {$urandom(), $urandom()};
                nextCycle();
            end
            bus.inValid = 1'b1;
            bus.inData  = wordQ[i];
            accepted    = 1'b0;
            budget      = 0;
            while (!accepted && budget < 50) begin
                accepted = bus.inReady;
                nextCycle();
                budget++;
            end
            if (!accepted) begin
                checkOutput("acceptTimeout", 64'd0, 64'd1);
            end
            if (i < n - 1) begin
                checkOutput("noEarlyEmit", {63'h0, bus.outValid}, 64'd0);
            end
        end
        bus.inValid = 1'b0;

        checkOutput("emitLatency", {63'h0, bus.outValid}, 64'd1);
        checkOutput("outSum", 64'(bus.outSum), expSum);
        checkOutput("outPcoeff", 64'(bus.outPcoeff), expPc);
        checkOutput("outCount", 64'(bus.outCount), 64'(n));
`ifdef TOP_ACC_OVERFLOW_DETECT_EN
        checkOutput("outOverflow", {63'h0, bus.outOverflow}, {63'h0, expOvf});
`else
        if (expOvf) begin
            $display("[TB] top wraps silently (overflow flag not built)");
        end
`endif

        for (int k = 0; k < holdCycles; k++) begin
            bus.outReady      = 1'b0;
            bus.inValid       = 1'b1;
            bus.inData        = {$urandom(), $urandom()};
            bus.startTop      = 1'b1;
            bus.expectedCount = COUNT_W'($urandom_range(1, 9));
            nextCycle();
            checkOutput("holdValid", {63'h0, bus.outValid}, 64'd1);
            checkOutput("holdSum", 64'(bus.outSum), expSum);
            checkOutput("holdCount", 64'(bus.outCount), 64'(n));
            checkOutput("holdInReady", {63'h0, bus.inReady}, 64'd0);
            checkOutput("holdTopReady", {63'h0, bus.topReady}, 64'd0);
        end
        bus.startTop = 1'b0;
        bus.inValid  = 1'b0;
        checkOutput("topReadyInEmit", {63'h0, bus.topReady}, 64'd0);
        bus.outReady = 1'b1;
        nextCycle();
        bus.outReady = 1'b0;
        checkOutput("releaseValid", {63'h0, bus.outValid}, 64'd0);
        checkOutput("releaseTopReady", {63'h0, bus.topReady}, 64'd1);
    endtask

    initial begin
        int total;
        int n;
        checkCount        = 0;
        errorCount        = 0;
        resetn            = 1'b0;
        bus.startTop      = 1'b0;
        bus.expectedCount = '0;
        bus.inValid       = 1'b0;
        bus.inData        = '0;
        bus.outReady      = 1'b0;
        repeat (3) nextCycle();
        checkOutput("resetTopReady", {63'h0, bus.topReady}, 64'd1);
        checkOutput("resetOutValid", {63'h0, bus.outValid}, 64'd0);
        checkOutput("resetInReady", {63'h0, bus.inReady}, 64'd0);
        checkOutput("resetOutSum", 64'(bus.outSum), 64'd0);
        checkOutput("resetOutCount", 64'(bus.outCount), 64'd0);
        resetn = 1'b1;
        nextCycle();

        $display("[TB] directed three-word top");
        wordQ = {64'h0001_000000000010, 64'h0002_000000000020, 64'h0003_000000000030};
        applyStimulus(0, 0);

        $display("[TB] zero-length top");
        wordQ.delete();
        applyStimulus(0, 2);

        $display("[TB] stalled record with competing inputs");
        wordQ = {{$urandom(), $urandom()}, {$urandom(), $urandom()}};
        applyStimulus(0, 5);

        $display("[TB] carry out of the sum accumulator, then a clean top");
        wordQ = {64'h0000_FFFFFFFFFFFF, 64'h0000_FFFFFFFFFFFF};
        applyStimulus(0, 0);
        wordQ = {64'h0005_000000000007};
        applyStimulus(0, 1);

        $display("[TB] 1000 random words with valid gaps");
        total = 0;
        while (total < 1000) begin
            n = $urandom_range(1, 60);
            if (total + n > 1000) n = 1000 - total;
            wordQ.delete();
            for (int i = 0; i < n; i++) wordQ.push_back({$urandom(), $urandom()});
            applyStimulus(30, $urandom_range(0, 3));
            total += n;
        end

        $display("[TB] reset mid-top");
        bus.startTop      = 1'b1;
        bus.expectedCount = COUNT_W'(5);
        nextCycle();
        bus.startTop = 1'b0;
        bus.inValid  = 1'b1;
        bus.inData   = 64'h0004_000000001234;
        repeat (2) nextCycle();
        bus.inValid = 1'b0;
        checkOutput("midTopSum", 64'(bus.outSum), 64'h2468);
        resetn = 1'b0;
        #1;
        checkOutput("asyncResetValid", {63'h0, bus.outValid}, 64'd0);
        checkOutput("asyncResetTopReady", {63'h0, bus.topReady}, 64'd1);
        checkOutput("asyncResetSum", 64'(bus.outSum), 64'd0);
        checkOutput("asyncResetPcoeff", 64'(bus.outPcoeff), 64'd0);
        nextCycle();
        resetn = 1'b1;
        nextCycle();
        wordQ = {64'h0001_000000000001};
        applyStimulus(0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end
endmodule
